// File: rtl/vga_pattern_gen.sv
// VGA timing generator and test-pattern source.
// Free-running col/row counters drive sync, data-enable and eight parallel
// pattern generators; a mode register sampled on the last pixel of each frame
// picks one. Everything leaving the block is registered once from counter
// state, so syncs, de, position and colour always describe the same pixel.

// Per-channel colour select: turns the per-pattern on/off mask for one
// channel into a sub-pixel value, with the grey ramp as the only graded case.
module vga_chan_sel #(
  parameter int W = 3
) (
  input  logic [3:0]   mode,
  input  logic [7:0]   on_mask,
  input  logic [W-1:0] ramp,
  input  logic         de,
  output logic [W-1:0] val
);

  // Blanking and modes 8..15 force black; mode 7 is the ramp, others full/off.
  always_comb begin
    val = '0;
    if (de && !mode[3]) begin
      if (mode[2:0] == 3'd7)        val = ramp;
      else if (on_mask[mode[2:0]])  val = '1;
    end
  end

endmodule

module vga_pattern_gen #(
  parameter int SUB_PIXEL_WIDTH = 3,
  parameter int TOTAL_COLS      = 800,
  parameter int TOTAL_ROWS      = 525,
  parameter int ACTIVE_COLS     = 640,
  parameter int ACTIVE_ROWS     = 480,
  parameter int H_FRONT_PORCH   = 16,
  parameter int H_SYNC_WIDTH    = 96,
  parameter int V_FRONT_PORCH   = 10,
  parameter int V_SYNC_WIDTH    = 2,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int CHECKER_SHIFT   = 5,
  parameter int BORDER          = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [3:0]                 i_pattern,
  output logic                       o_hsync,
  output logic                       o_vsync,
  output logic                       o_de,
  output logic                       o_frame_start,
  output logic [9:0]                 o_col,
  output logic [9:0]                 o_row,
  output logic [SUB_PIXEL_WIDTH-1:0] o_red_video,
  output logic [SUB_PIXEL_WIDTH-1:0] o_grn_video,
  output logic [SUB_PIXEL_WIDTH-1:0] o_blu_video
);

  localparam int NUM_CH = 3;  // 0 red, 1 green, 2 blue
  localparam int SPW    = SUB_PIXEL_WIDTH;

  // Compare limits are 11 bits wide so an end bound of exactly 1024 still fits.
  localparam logic [9:0]  COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]  ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [10:0] AC_L     = 11'(ACTIVE_COLS);
  localparam logic [10:0] AR_L     = 11'(ACTIVE_ROWS);
  localparam logic [10:0] HS_BEG   = 11'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [10:0] HS_END   = 11'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [10:0] VS_BEG   = 11'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [10:0] VS_END   = 11'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH);
  localparam logic [10:0] BRD_L    = 11'(BORDER);
  localparam logic [10:0] BOX_R    = 11'(ACTIVE_COLS - BORDER);
  localparam logic [10:0] BOX_B    = 11'(ACTIVE_ROWS - BORDER);
  localparam int          BAR_W    = (ACTIVE_COLS / 8 > 0) ? ACTIVE_COLS / 8 : 1;
  localparam logic        SYNC_OFF = 1'(SYNC_ACTIVE_LOW != 0);

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       de;
    logic       frame_start;
    logic [9:0] col;
    logic [9:0] row;
  } timing_t;

  logic [9:0]  col_q, row_q;
  logic [10:0] col_x, row_x;
  logic [3:0]  mode_q;
  logic        frame_end;

  assign col_x     = {1'b0, col_q};
  assign row_x     = {1'b0, row_q};
  assign frame_end = (col_q == COL_LAST) && (row_q == ROW_LAST);

  // Raster counters: column wraps into a row step, row wraps at frame end.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (col_q == COL_LAST) begin
      col_q <= '0;
      row_q <= (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
    end else begin
      col_q <= col_q + 10'd1;
    end
  end

  // Mode changes only on the last pixel so the new pattern starts at (0,0).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)     mode_q <= '0;
    else if (frame_end) mode_q <= i_pattern;
  end

  // Timing decode for the pixel the counters currently point at.
  timing_t tim_d, tim_q;
  logic    hs_on, vs_on;

  assign hs_on = (col_x >= HS_BEG) && (col_x < HS_END);
  assign vs_on = (row_x >= VS_BEG) && (row_x < VS_END);

  always_comb begin
    tim_d             = '0;
    tim_d.hsync       = hs_on ? ~SYNC_OFF : SYNC_OFF;
    tim_d.vsync       = vs_on ? ~SYNC_OFF : SYNC_OFF;
    tim_d.de          = (col_x < AC_L) && (row_x < AR_L);
    tim_d.frame_start = (col_q == 10'd0) && (row_q == 10'd0);
    tim_d.col         = col_q;
    tim_d.row         = row_q;
  end

  // Pattern features shared by all channels.
  logic [9:0]     bar_idx;
  logic [2:0]     bar_rgb;   // bit 0 red, 1 green, 2 blue
  logic           chk_white, box_white;
  logic [SPW-1:0] ramp;

  assign bar_idx   = 10'(32'(col_q) / BAR_W);
  assign chk_white = ~(col_q[CHECKER_SHIFT] ^ row_q[CHECKER_SHIFT]);
  assign box_white = (col_x < BRD_L) || (col_x >= BOX_R) ||
                     (row_x < BRD_L) || (row_x >= BOX_B);
  assign ramp      = col_q[CHECKER_SHIFT+SPW-1:CHECKER_SHIFT];

  // Colour-bar lookup; anything past the eighth bar is black.
  always_comb begin
    bar_rgb = 3'b000;
    case (bar_idx)
      10'd0:   bar_rgb = 3'b111;  // white
      10'd1:   bar_rgb = 3'b011;  // yellow
      10'd2:   bar_rgb = 3'b110;  // cyan
      10'd3:   bar_rgb = 3'b010;  // green
      10'd4:   bar_rgb = 3'b101;  // magenta
      10'd5:   bar_rgb = 3'b001;  // red
      10'd6:   bar_rgb = 3'b100;  // blue
      default: bar_rgb = 3'b000;  // black bar and remainder
    endcase
  end

  logic [NUM_CH-1:0][7:0]     pat_on;
  logic [NUM_CH-1:0][SPW-1:0] chan_d, chan_q;

  genvar ch;
  generate
    for (ch = 0; ch < NUM_CH; ch++) begin : g_chan
      // Mask bit n = channel lit for pattern n (7 is the ramp, handled below).
      assign pat_on[ch] = {1'b0, box_white, bar_rgb[ch], chk_white,
                           1'(ch == 2), 1'(ch == 1), 1'(ch == 0), 1'b0};

      vga_chan_sel #(.W(SPW)) u_chan (
        .mode    (mode_q),
        .on_mask (pat_on[ch]),
        .ramp    (ramp),
        .de      (tim_d.de),
        .val     (chan_d[ch])
      );
    end
  endgenerate

  // Single output register stage keeps timing and colour aligned.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tim_q  <= '{hsync: SYNC_OFF, vsync: SYNC_OFF, de: 1'b0,
                  frame_start: 1'b0, col: 10'd0, row: 10'd0};
      chan_q <= '0;
    end else begin
      tim_q  <= tim_d;
      chan_q <= chan_d;
    end
  end

  assign o_hsync       = tim_q.hsync;
  assign o_vsync       = tim_q.vsync;
  assign o_de          = tim_q.de;
  assign o_frame_start = tim_q.frame_start;
  assign o_col         = tim_q.col;
  assign o_row         = tim_q.row;
  assign o_red_video   = chan_q[0];
  assign o_grn_video   = chan_q[1];
  assign o_blu_video   = chan_q[2];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen. Full-width lines (800 cols) keep the
// horizontal numbers identical to the default mode; the frame is only 12 rows
// tall so several frames fit in a short run. Vertical landmarks:
// active rows 0..7, vsync rows 9..10, box bottom border rows 6..7.
module tb_vga_pattern_gen;

  localparam int TC = 800, TR = 12, AC = 640, AR = 8;
  localparam int HFP = 16, HSW = 96, VFP = 1, VSW = 2;
  localparam int CS = 2, BRD = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pat;
  logic       o_hsync, o_vsync, o_de, o_frame_start;
  logic [9:0] o_col, o_row;
  logic [2:0] o_red, o_grn, o_blu;
  logic [8:0] pix;

  int n_cmp = 0;
  int n_bad = 0;

  assign pix = {o_red, o_grn, o_blu};

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .SUB_PIXEL_WIDTH(3), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW),
    .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW),
    .SYNC_ACTIVE_LOW(1), .CHECKER_SHIFT(CS), .BORDER(BRD)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_pattern(pat),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .o_frame_start(o_frame_start), .o_col(o_col), .o_row(o_row),
    .o_red_video(o_red), .o_grn_video(o_grn), .o_blu_video(o_blu)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the outputs show pixel (c,r); a missed target is a failure.
  task automatic run_to(input int c, input int r);
    int guard = 0;
    while (!(o_col == 10'(c) && o_row == 10'(r))) begin
      if (guard == 12000) begin
        n_cmp++; n_bad++;
        $display("FAIL run_to: pixel (%0d,%0d) never reached, at (%0d,%0d)", c, r, o_col, o_row);
        return;
      end
      tick();
      guard++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pat   = 4'd0;
    repeat (5) tick();
    n_cmp++; if (o_hsync !== 1'b1) begin n_bad++; $display("FAIL rst_hsync: got %b want 1", o_hsync); end
    n_cmp++; if (o_vsync !== 1'b1) begin n_bad++; $display("FAIL rst_vsync: got %b want 1", o_vsync); end
    n_cmp++; if (o_de !== 1'b0) begin n_bad++; $display("FAIL rst_de: got %b want 0", o_de); end
    n_cmp++; if (o_frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_fs: got %b want 0", o_frame_start); end
    n_cmp++; if (pix !== 9'o000) begin n_bad++; $display("FAIL rst_video: got %o want 000", pix); end
    n_cmp++; if (o_col !== 10'd0 || o_row !== 10'd0) begin n_bad++; $display("FAIL rst_pos: got (%0d,%0d) want (0,0)", o_col, o_row); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (o_col !== 10'd0 || o_row !== 10'd0) begin n_bad++; $display("FAIL first_pos: got (%0d,%0d) want (0,0)", o_col, o_row); end
    n_cmp++; if (o_frame_start !== 1'b1) begin n_bad++; $display("FAIL first_fs: got %b want 1", o_frame_start); end
    n_cmp++; if (o_de !== 1'b1) begin n_bad++; $display("FAIL first_de: got %b want 1", o_de); end
    n_cmp++; if (o_hsync !== 1'b1 || o_vsync !== 1'b1) begin n_bad++; $display("FAIL first_sync: got %b%b want 11", o_hsync, o_vsync); end
    n_cmp++; if (pix !== 9'o000) begin n_bad++; $display("FAIL first_video: got %o want 000", pix); end
  endtask

  // One line from (0,0): hsync low for exactly cols 656..751, de low 640..799.
  task automatic test_hsync_line();
    int lo = 0, lo_first = -1, lo_last = -1, de_lo = 0, de_first = -1, pos_bad = 0;
    for (int k = 0; k < TC; k++) begin
      if (o_col !== 10'(k) || o_row !== 10'd0) pos_bad++;
      if (o_hsync === 1'b0) begin lo++; if (lo_first < 0) lo_first = k; lo_last = k; end
      if (o_de === 1'b0) begin de_lo++; if (de_first < 0) de_first = k; end
      tick();
    end
    n_cmp++; if (pos_bad != 0) begin n_bad++; $display("FAIL line_pos: %0d bad positions want 0", pos_bad); end
    n_cmp++; if (lo != 96) begin n_bad++; $display("FAIL hsync_len: got %0d want 96", lo); end
    n_cmp++; if (lo_first != 656) begin n_bad++; $display("FAIL hsync_first: got %0d want 656", lo_first); end
    n_cmp++; if (lo_last != 751) begin n_bad++; $display("FAIL hsync_last: got %0d want 751", lo_last); end
    n_cmp++; if (de_lo != 160) begin n_bad++; $display("FAIL de_lo_len: got %0d want 160", de_lo); end
    n_cmp++; if (de_first != 640) begin n_bad++; $display("FAIL de_lo_first: got %0d want 640", de_first); end
  endtask

  // One full frame from (0,1) against an independent raster model. Pattern 5
  // is requested at the start; it must stay invisible until the next (0,0).
  task automatic test_frame();
    int ec = 0, er = 1;
    int pos_bad = 0, h_bad = 0, v_bad = 0, de_bad = 0, fs_bad = 0;
    int v_lo = 0, fs_cnt = 0, blank_bad = 0, tear_bad = 0;
    bit e_h, e_v, e_de, e_fs, seen_fs = 1'b0;
    pat = 4'd5;
    for (int i = 0; i < TC * TR; i++) begin
      e_h  = (ec >= AC + HFP) && (ec < AC + HFP + HSW);
      e_v  = (er >= AR + VFP) && (er < AR + VFP + VSW);
      e_de = (ec < AC) && (er < AR);
      e_fs = (ec == 0) && (er == 0);
      if (e_fs) seen_fs = 1'b1;
      if (o_col !== 10'(ec) || o_row !== 10'(er)) pos_bad++;
      if (o_hsync !== !e_h) h_bad++;
      if (o_vsync !== !e_v) v_bad++;
      if (o_vsync === 1'b0) v_lo++;
      if (o_de !== e_de) de_bad++;
      if (o_frame_start === 1'b1) fs_cnt++;
      if (o_frame_start !== e_fs) fs_bad++;
      if (!e_de && pix !== 9'o000) blank_bad++;
      if (!seen_fs && e_de && pix !== 9'o000) tear_bad++;
      ec++;
      if (ec == TC) begin ec = 0; er = (er == TR - 1) ? 0 : er + 1; end
      tick();
    end
    n_cmp++; if (pos_bad != 0) begin n_bad++; $display("FAIL frame_pos: %0d bad want 0", pos_bad); end
    n_cmp++; if (h_bad != 0) begin n_bad++; $display("FAIL frame_hsync: %0d bad want 0", h_bad); end
    n_cmp++; if (v_bad != 0) begin n_bad++; $display("FAIL frame_vsync: %0d bad want 0", v_bad); end
    n_cmp++; if (v_lo != 2 * TC) begin n_bad++; $display("FAIL vsync_len: got %0d want %0d", v_lo, 2 * TC); end
    n_cmp++; if (de_bad != 0) begin n_bad++; $display("FAIL frame_de: %0d bad want 0", de_bad); end
    n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL fs_count: got %0d want 1", fs_cnt); end
    n_cmp++; if (fs_bad != 0) begin n_bad++; $display("FAIL fs_place: %0d bad want 0", fs_bad); end
    n_cmp++; if (blank_bad != 0) begin n_bad++; $display("FAIL blank_video: %0d nonzero want 0", blank_bad); end
    n_cmp++; if (tear_bad != 0) begin n_bad++; $display("FAIL no_tear: %0d early pixels want 0", tear_bad); end
  endtask

  // Bars now showing (frame started inside test_frame); checked on row 1.
  task automatic test_color_bars();
    int         c [10] = '{0, 79, 80, 160, 240, 320, 400, 480, 560, 639};
    logic [8:0] e [10] = '{9'o777, 9'o777, 9'o770, 9'o077, 9'o070,
                           9'o707, 9'o700, 9'o007, 9'o000, 9'o000};
    for (int k = 0; k < 10; k++) begin
      run_to(c[k], 1);
      n_cmp++; if (pix !== e[k]) begin n_bad++; $display("FAIL bars(%0d,1): got %o want %o", c[k], pix, e[k]); end
    end
    n_cmp++; if (o_de !== 1'b1) begin n_bad++; $display("FAIL bars_de639: got %b want 1", o_de); end
    pat = 4'd4;
    run_to(80, 2);
    n_cmp++; if (pix !== 9'o770) begin n_bad++; $display("FAIL bars_hold(80,2): got %o want 770", pix); end
  endtask

  task automatic test_checker();
    int         c [6] = '{0, 3, 4, 8, 0, 4};
    int         r [6] = '{0, 0, 0, 0, 4, 4};
    logic [8:0] e [6] = '{9'o777, 9'o777, 9'o000, 9'o777, 9'o000, 9'o777};
    for (int k = 0; k < 6; k++) begin
      run_to(c[k], r[k]);
      n_cmp++; if (pix !== e[k]) begin n_bad++; $display("FAIL checker(%0d,%0d): got %o want %o", c[k], r[k], pix, e[k]); end
    end
    pat = 4'd7;
  endtask

  task automatic test_grey_ramp();
    int         c [8] = '{0, 4, 28, 31, 32, 100, 639, 640};
    int         r [8] = '{0, 0, 0, 0, 0, 2, 2, 2};
    logic [8:0] e [8] = '{9'o000, 9'o111, 9'o777, 9'o777, 9'o000, 9'o111, 9'o777, 9'o000};
    for (int k = 0; k < 8; k++) begin
      run_to(c[k], r[k]);
      n_cmp++; if (pix !== e[k]) begin n_bad++; $display("FAIL grey(%0d,%0d): got %o want %o", c[k], r[k], pix, e[k]); end
    end
    pat = 4'd12;
  endtask

  // Modes 8..15 are black even though they follow a lit pattern.
  task automatic test_high_modes_black();
    int c [3] = '{0, 28, 100};
    int r [3] = '{0, 0, 2};
    for (int k = 0; k < 3; k++) begin
      run_to(c[k], r[k]);
      n_cmp++; if (pix !== 9'o000 || o_de !== 1'b1) begin n_bad++; $display("FAIL mode12(%0d,%0d): got %o de %b want 000 de 1", c[k], r[k], pix, o_de); end
    end
    pat = 4'd1;
  endtask

  // Red frame; box requested mid-frame must wait for the next (0,0).
  task automatic test_pattern_switch();
    int         c1 [6] = '{0, 639, 640, 0, 0, 639};
    int         r1 [6] = '{0, 0, 0, 5, 7, 7};
    logic [8:0] e1 [6] = '{9'o700, 9'o700, 9'o000, 9'o700, 9'o700, 9'o700};
    int         c2 [8] = '{0, 2, 637, 638, 1, 5, 5, 639};
    int         r2 [8] = '{0, 2, 3, 3, 5, 5, 6, 7};
    logic [8:0] e2 [8] = '{9'o777, 9'o000, 9'o000, 9'o777, 9'o777, 9'o000, 9'o777, 9'o777};
    for (int k = 0; k < 6; k++) begin
      run_to(c1[k], r1[k]);
      if (k == 3) pat = 4'd6;
      n_cmp++; if (pix !== e1[k]) begin n_bad++; $display("FAIL red(%0d,%0d): got %o want %o", c1[k], r1[k], pix, e1[k]); end
    end
    for (int k = 0; k < 8; k++) begin
      run_to(c2[k], r2[k]);
      n_cmp++; if (pix !== e2[k]) begin n_bad++; $display("FAIL box(%0d,%0d): got %o want %o", c2[k], r2[k], pix, e2[k]); end
    end
  endtask

  // Async reset in the middle of a visible line, then a clean restart.
  task automatic test_reset_mid_frame();
    run_to(300, 2);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (o_col !== 10'd0 || o_row !== 10'd0) begin n_bad++; $display("FAIL mid_rst_pos: got (%0d,%0d) want (0,0)", o_col, o_row); end
    n_cmp++; if (o_de !== 1'b0 || o_frame_start !== 1'b0) begin n_bad++; $display("FAIL mid_rst_de_fs: got %b%b want 00", o_de, o_frame_start); end
    n_cmp++; if (o_hsync !== 1'b1 || o_vsync !== 1'b1) begin n_bad++; $display("FAIL mid_rst_sync: got %b%b want 11", o_hsync, o_vsync); end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (o_col !== 10'd0 || o_row !== 10'd0 || o_frame_start !== 1'b1) begin n_bad++; $display("FAIL restart: got (%0d,%0d) fs %b want (0,0) fs 1", o_col, o_row, o_frame_start); end
    n_cmp++; if (o_de !== 1'b1 || pix !== 9'o000) begin n_bad++; $display("FAIL restart_mode: got de %b pix %o want de 1 pix 000", o_de, pix); end
    tick();
    n_cmp++; if (o_col !== 10'd1 || o_frame_start !== 1'b0) begin n_bad++; $display("FAIL restart_next: got col %0d fs %b want col 1 fs 0", o_col, o_frame_start); end
  endtask

  initial begin
    test_reset();
    test_hsync_line();
    test_frame();
    test_color_bars();
    test_checker();
    test_grey_ramp();
    test_high_modes_black();
    test_pattern_switch();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
